// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a synchronous-read data RAM. Port 0 has fixed priority.
// A starvation counter lets port 1 win; read data returns one cycle later, tagged per port.
module dmem_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [3:0]        p0_wen,
   input  logic [31:0]       p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [31:0]       p0_rdata,
   input  logic              p1_req,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [3:0]        p1_wen,
   input  logic [31:0]       p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [31:0]       p1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [3:0]        ram_wen,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [1:0] {StIdle, StRspP0, StRspP1} rsp_state_e;

   rsp_state_e state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       starved;

   assign starved = (wait_cnt_q >= 8'(STARVE_LIMIT));

   // Port 1 wins when alone or once it has lost STARVE_LIMIT cycles in a row.
   assign p1_gnt = p1_req & (~p0_req | starved);
   assign p0_gnt = p0_req & ~p1_gnt;

   always_comb begin
      ram_addr  = p0_addr;
      ram_wen   = 4'b0000;
      ram_wdata = p0_wdata;
      if (p1_gnt) begin
         ram_addr  = p1_addr;
         ram_wen   = p1_wen;
         ram_wdata = p1_wdata;
      end else if (p0_gnt) begin
         ram_wen   = p0_wen;
      end
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!p1_req || p1_gnt) begin
         wait_cnt_d = 8'd0;
      end else if (wait_cnt_q < 8'(STARVE_LIMIT)) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

   // Track which port owns the RAM data returning next cycle; only reads produce a response.
   always_comb begin
      state_d = StIdle;
      if (p0_gnt && (p0_wen == 4'b0000)) begin
         state_d = StRspP0;
      end else if (p1_gnt && (p1_wen == 4'b0000)) begin
         state_d = StRspP1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign p0_rvalid = (state_q == StRspP0);
   assign p1_rvalid = (state_q == StRspP1);
   assign p0_rdata  = p0_rvalid ? ram_rdata : 32'd0;
   assign p1_rdata  = p1_rvalid ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, rule-level arbitration model, per-port response
// scoreboard queues checked by a separate monitor, directed cases then random traffic.
module tb_dmem_arbiter;
   localparam int unsigned AW    = 32;
   localparam int unsigned LIMIT = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          p0_req, p1_req;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [3:0]    p0_wen, p1_wen;
   logic [31:0]   p0_wdata, p1_wdata;
   logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [31:0]   p0_rdata, p1_rdata;
   logic [AW-1:0] ram_addr;
   logic [3:0]    ram_wen;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata = 32'd0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_wen(p0_wen), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_wen(p1_wen), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // Environment RAM: 64 words, synchronous read, byte-enabled write.
   logic [31:0] ram     [64];
   logic [31:0] ref_mem [64];

   always @(posedge clk) begin
      ram_rdata <= ram[ram_addr[7:2]];
      for (int b = 0; b < 4; b++)
         if (ram_wen[b]) ram[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
   end

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   typedef struct {
      int unsigned due;
      logic [31:0] data;
   } rsp_t;

   rsp_t        q0[$];
   rsp_t        q1[$];
   int unsigned mwait = 0;
   logic        log_en = 1'b0;
   logic [1:0]  win_log[$];

   // Reference model: decide the winner from the request rules, predict RAM drive and responses.
   always @(negedge clk) begin : model
      int          win;
      logic [31:0] a;
      logic [3:0]  w;
      logic [31:0] d;
      rsp_t        r;
      if (!rst) begin
         if (p0_req && p1_req) win = (mwait >= LIMIT) ? 1 : 0;
         else if (p0_req)      win = 0;
         else if (p1_req)      win = 1;
         else                  win = -1;
         a = (win == 1) ? p1_addr : p0_addr;
         w = (win == 1) ? p1_wen : (win == 0) ? p0_wen : 4'b0000;
         d = (win == 1) ? p1_wdata : p0_wdata;
         check("gnt", 64'({p1_gnt, p0_gnt}), 64'({win == 1, win == 0}));
         check("ram_addr", 64'(ram_addr), 64'(a));
         check("ram_wen", 64'(ram_wen), 64'(w));
         if (win >= 0) check("ram_wdata", 64'(ram_wdata), 64'(d));
         if (log_en) win_log.push_back({p1_gnt, p0_gnt});
         if (win >= 0) begin
            if (w == 4'b0000) begin
               r.due  = cyc + 1;
               r.data = ref_mem[a[7:2]];
               if (win == 0) q0.push_back(r);
               else          q1.push_back(r);
            end else begin
               for (int b = 0; b < 4; b++)
                  if (w[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
            end
         end
         if (p1_req && win != 1) mwait = (mwait < LIMIT) ? mwait + 1 : mwait;
         else                    mwait = 0;
      end
   end

   // Monitor: rvalid must appear exactly when a response is due, with the predicted data.
   always @(negedge clk) begin : monitor
      logic due0, due1;
      due0 = (q0.size() > 0) && (q0[0].due == cyc);
      due1 = (q1.size() > 0) && (q1[0].due == cyc);
      check("p0_rvalid", 64'(p0_rvalid), 64'(due0));
      check("p1_rvalid", 64'(p1_rvalid), 64'(due1));
      if (due0) begin
         if (p0_rvalid) check("p0_rdata", 64'(p0_rdata), 64'(q0[0].data));
         void'(q0.pop_front());
      end
      if (due1) begin
         if (p1_rvalid) check("p1_rdata", 64'(p1_rdata), 64'(q1[0].data));
         void'(q1.pop_front());
      end
   end

   task automatic set_req(input int port, input logic [31:0] a, input logic [3:0] w,
                          input logic [31:0] d);
      if (port == 0) begin
         p0_req = 1'b1; p0_addr = a; p0_wen = w; p0_wdata = d;
      end else begin
         p1_req = 1'b1; p1_addr = a; p1_wen = w; p1_wdata = d;
      end
   endtask

   task automatic clr(input int port);
      if (port == 0) p0_req = 1'b0;
      else           p1_req = 1'b0;
   endtask

   task automatic rand_req(input int port);
      logic [31:0] a;
      logic [3:0]  w;
      a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      set_req(port, a, w, $urandom);
   endtask

   task automatic wait_gnt(input int port);
      int n = 0;
      forever begin
         @(negedge clk);
         if ((port == 0) ? p0_gnt : p1_gnt) break;
         n++;
         if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL gnt_timeout: port %0d got no grant expected grant within 50", port);
            break;
         end
      end
      @(posedge clk); #1;
      clr(port);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      p0_req = 1'b0;
      p1_req = 1'b0;
      q0.delete();
      q1.delete();
      mwait = 0;
      idle(2);
      rst = 1'b0;
   endtask

   // Both ports request continuously: p0 wins LIMIT cycles, p1 the next, then p0 again.
   task automatic starve_run();
      logic [1:0] exp;
      win_log.delete();
      log_en = 1'b1;
      set_req(0, 32'h10, 4'b0000, 32'd0);
      set_req(1, 32'h30, 4'b1111, 32'h1234_5678);
      repeat (LIMIT + 2) @(negedge clk);
      @(posedge clk); #1;
      log_en = 1'b0;
      clr(0);
      clr(1);
      check("starve_len", 64'(win_log.size()), 64'(LIMIT + 2));
      for (int i = 0; i < LIMIT + 2; i++) begin
         exp = (i == LIMIT) ? 2'b10 : 2'b01;
         check($sformatf("starve_gnt_%0d", i), 64'((i < win_log.size()) ? win_log[i] : 2'b00),
               64'(exp));
      end
   endtask

   initial begin
      logic g0, g1;
      rst = 1'b1;
      p0_req = 1'b0; p0_addr = '0; p0_wen = '0; p0_wdata = '0;
      p1_req = 1'b0; p1_addr = '0; p1_wen = '0; p1_wdata = '0;
      for (int i = 0; i < 64; i++) begin
         ram[i]     = 32'(i) * 32'h0101_0101 ^ 32'h5A00_0000;
         ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A00_0000;
      end
      ram[4]     = 32'hDEAD_BEEF;
      ref_mem[4] = 32'hDEAD_BEEF;
      idle(3);
      rst = 1'b0;

      // Idle: no grants, no writes, no responses.
      idle(10);

      // Plain p0 read of the preloaded word.
      set_req(0, 32'h10, 4'b0000, 32'd0);
      wait_gnt(0);
      idle(2);

      // Byte store into lane 2, then read the word back.
      set_req(0, 32'h22, 4'b0100, 32'h00AB_0000);
      wait_gnt(0);
      set_req(0, 32'h20, 4'b0000, 32'd0);
      wait_gnt(0);
      idle(2);

      starve_run();
      idle(2);

      // Alternating single-cycle reads across ports.
      set_req(0, 32'h0, 4'b0000, 32'd0);
      idle(1);
      clr(0);
      set_req(1, 32'h4, 4'b0000, 32'd0);
      idle(1);
      clr(1);
      set_req(0, 32'h8, 4'b0000, 32'd0);
      idle(1);
      clr(0);
      idle(3);

      // Reset right after a p1 read grant drops the pending response.
      set_req(1, 32'h10, 4'b0000, 32'd0);
      wait_gnt(1);
      do_reset();
      idle(1);

      // Reset during contention must restart the starvation count.
      set_req(0, 32'h8, 4'b0000, 32'd0);
      set_req(1, 32'h10, 4'b0000, 32'd0);
      idle(3);
      do_reset();
      starve_run();
      idle(1);
      set_req(1, 32'h10, 4'b0000, 32'd0);
      wait_gnt(1);
      idle(2);

      // Random traffic with abandons and back-to-back requests.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         g0 = p0_gnt;
         g1 = p1_gnt;
         @(posedge clk); #1;
         if (p0_req && !g0) begin
            if ($urandom_range(0, 19) == 0) p0_req = 1'b0;
         end else if ($urandom_range(0, 9) < 7) rand_req(0);
         else p0_req = 1'b0;
         if (p1_req && !g1) begin
            if ($urandom_range(0, 19) == 0) p1_req = 1'b0;
         end else if ($urandom_range(0, 9) < 5) rand_req(1);
         else p1_req = 1'b0;
      end
      @(posedge clk); #1;
      clr(0);
      clr(1);
      idle(3);
      check("q0_drained", 64'(q0.size()), 64'd0);
      check("q1_drained", 64'(q1.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
